// File: rtl/tdm_demux4.sv
// ============================================================================
// Module   : tdm_demux4
// Brief    : 1:4 TDM demultiplexer. A hunt/lock flywheel tracks frame alignment,
//            and each complete four-slot frame is presented on all channels at once.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4 #(
  parameter int WIDTH      = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             frame_valid,
  output logic [3:0]       slot_onehot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic [0:0] {
    S_HUNT = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  // Testing miss_cnt < MISS_LIMIT-1 is the same as miss_cnt+1 < MISS_LIMIT,
  // but it needs no extra carry bit.
  localparam logic [3:0] C_MISS_MAX = 4'(MISS_LIMIT - 1);

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [3:0]       miss_q, miss_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic [WIDTH-1:0] dout2_q, dout2_d, dout3_q, dout3_d;
  logic             fv_q, fv_d, serr_q, serr_d, locked_q, locked_d;
  logic [3:0]       onehot_q, onehot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HUNT;
      slot_q   <= 2'd0;
      miss_q   <= 4'd0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      dout0_q  <= '0;
      dout1_q  <= '0;
      dout2_q  <= '0;
      dout3_q  <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
      locked_q <= 1'b0;
      onehot_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      dout0_q  <= dout0_d;
      dout1_q  <= dout1_d;
      dout2_q  <= dout2_d;
      dout3_q  <= dout3_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
      locked_q <= locked_d;
      onehot_q <= onehot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    dout0_d  = dout0_q;
    dout1_d  = dout1_q;
    dout2_d  = dout2_q;
    dout3_d  = dout3_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;

    if (din_valid) begin
      if (state_q == S_HUNT) begin
        if (frame_sync) begin
          sh0_d   = din;
          slot_d  = 2'd1;
          miss_d  = 4'd0;
          state_d = S_LOCK;
        end
      end else if (frame_sync && (slot_q != 2'd0)) begin
        // A sync in the wrong slot realigns onto this sample.
        serr_d = 1'b1;
        sh0_d  = din;
        slot_d = 2'd1;
        miss_d = 4'd0;
      end else begin
        case (slot_q)
          2'd0: begin
            if (frame_sync) begin
              sh0_d  = din;
              miss_d = 4'd0;
              slot_d = 2'd1;
            end else if (miss_q < C_MISS_MAX) begin
              sh0_d  = din;
              miss_d = miss_q + 4'd1;
              slot_d = 2'd1;
            end else begin
              state_d = S_HUNT;
              slot_d  = 2'd0;
              miss_d  = 4'd0;
            end
          end
          2'd1: begin
            sh1_d  = din;
            slot_d = 2'd2;
          end
          2'd2: begin
            sh2_d  = din;
            slot_d = 2'd3;
          end
          default: begin
            dout0_d = sh0_q;
            dout1_d = sh1_q;
            dout2_d = sh2_q;
            dout3_d = din;
            fv_d    = 1'b1;
            slot_d  = 2'd0;
          end
        endcase
      end
    end

    locked_d = (state_d == S_LOCK);
    onehot_d = (state_d == S_LOCK) ? (4'b0001 << slot_d) : 4'b0000;
  end

  assign dout0       = dout0_q;
  assign dout1       = dout1_q;
  assign dout2       = dout2_q;
  assign dout3       = dout3_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign locked      = locked_q;
  assign slot_onehot = onehot_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// ============================================================================
// Module   : tb_tdm_demux4
// Brief    : Self-checking bench for tdm_demux4; a frame-queue reference model
//            is compared against the DUT after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux4;
  localparam int W  = 8;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] dout0, dout1, dout2, dout3;
  logic         frame_valid, locked, sync_err;
  logic [3:0]   slot_onehot;
  logic [4*W+7:0] dut_vec;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout0(dout0), .dout1(dout1), .dout2(dout2),
    .dout3(dout3), .frame_valid(frame_valid), .slot_onehot(slot_onehot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  assign dut_vec = {dout0, dout1, dout2, dout3, frame_valid, sync_err, locked, slot_onehot};

  // Reference model: the partial frame is a queue; its length is the next slot.
  bit           m_locked;
  int           m_miss;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_out[4];
  bit           m_fv, m_serr;

  function automatic void model_reset();
    m_locked = 0;
    m_miss   = 0;
    m_q.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_fv   = 0;
    m_serr = 0;
  endfunction

  function automatic void model_accept(bit fs, logic [W-1:0] d);
    m_fv   = 0;
    m_serr = 0;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1;
        m_q.delete();
        m_q.push_back(d);
        m_miss = 0;
      end
    end else if (fs && m_q.size() != 0) begin
      m_serr = 1;
      m_q.delete();
      m_q.push_back(d);
      m_miss = 0;
    end else if (m_q.size() == 0) begin
      if (fs) begin
        m_q.push_back(d);
        m_miss = 0;
      end else if (m_miss + 1 < ML) begin
        m_q.push_back(d);
        m_miss++;
      end else begin
        m_locked = 0;
        m_miss   = 0;
      end
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
        m_fv = 1;
        m_q.delete();
      end
    end
  endfunction

  function automatic logic [4*W+7:0] exp_vec();
    logic [3:0] oh;
    oh = m_locked ? 4'(1 << m_q.size()) : 4'b0000;
    return {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_serr, m_locked, oh};
  endfunction

  // Applies one cycle of input, advances the model, returns 1 ns after the edge.
  task automatic drive(input bit v, input bit fs, input logic [W-1:0] d);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    if (v) model_accept(fs, d);
    else begin
      m_fv   = 0;
      m_serr = 0;
    end
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_frame();
    logic [W-1:0] s[4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [3:0]   oh[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, s[i]);
      checks++;
      if (dut_vec !== exp_vec() || slot_onehot !== oh[i] || locked !== 1'b1) begin
        errors++;
        $display("FAIL one_frame[%0d] got=%h exp=%h oh_exp=%b", i, dut_vec, exp_vec(), oh[i]);
      end
    end
    checks++;
    if ({dout0, dout1, dout2, dout3, frame_valid} !== {32'hA1B2C3D4, 1'b1}) begin
      errors++;
      $display("FAIL one_frame_dout got=%h%h%h%h fv=%b exp=a1b2c3d4 fv=1",
               dout0, dout1, dout2, dout3, frame_valid);
    end
    drive(0, 0, '0);
    checks++;
    if (frame_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL one_frame_pulse got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] s[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, s[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL gapped_sample[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      for (int g = 0; g < 3; g++) begin
        drive(0, 1, 8'hFF);
        checks++;
        if (dut_vec !== exp_vec() || frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL gapped_idle[%0d.%0d] got=%h exp=%h", i, g, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_misplaced_sync();
    logic [W-1:0] s[6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bit           fs[6] = '{1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, fs[i], s[i]);
      checks++;
      if (dut_vec !== exp_vec() || sync_err !== (i == 2)) begin
        errors++;
        $display("FAIL misplaced[%0d] got=%h exp=%h serr=%b", i, dut_vec, exp_vec(), sync_err);
      end
    end
    checks++;
    if ({dout0, dout1, dout2, dout3} !== 32'h33445566) begin
      errors++;
      $display("FAIL misplaced_dout got=%h%h%h%h exp=33445566", dout0, dout1, dout2, dout3);
    end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'(8'h70 + i));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lol[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (locked !== 1'b0 || slot_onehot !== 4'b0000) begin
          errors++;
          $display("FAIL lol_drop locked=%b oh=%b exp locked=0 oh=0000", locked, slot_onehot);
        end
      end
    end
    checks++;
    if ({dout0, dout1, dout2, dout3} !== 32'h70717273) begin
      errors++;
      $display("FAIL lol_hold got=%h%h%h%h exp=70717273", dout0, dout1, dout2, dout3);
    end
  endtask

  task automatic test_hunt_discard();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'(8'h90 + i));
      checks++;
      if (locked !== 1'b0 || frame_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL hunt[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) drive(1, i == 0, 8'(8'hE0 + i));
    checks++;
    if ({dout0, dout1, dout2, dout3, frame_valid} !== {32'hE0E1E2E3, 1'b1}) begin
      errors++;
      $display("FAIL hunt_frame got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_midframe();
    drive(1, 1, 8'hAA);
    drive(1, 0, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive(1, i == 0, 8'(i + 1));
    checks++;
    if ({dout0, dout1, dout2, dout3} !== 32'h01020304 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_frame got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 9) < 8);
      // Mostly well-formed syncs on slot 0, with occasional stray or missing ones.
      if (m_locked && m_q.size() == 0) fs = ($urandom_range(0, 9) < 8);
      else fs = ($urandom_range(0, 9) < 1) || (!m_locked && $urandom_range(0, 3) == 0);
      drive(v, fs, W'($urandom));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_one_frame();
    test_gapped();
    test_misplaced_sync();
    test_loss_of_lock();
    test_hunt_discard();
    test_reset_midframe();
    test_random();
    test_one_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
